// File: rtl/ros2_buf_arbiter_if.sv
// ros2_buf_arbiter_if: en/req/rel/timeout_cycles in, grant/grant_idx/busy/timeout_pulse/timeout_idx out
interface ros2_buf_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_WIDTH = 24
);
  localparam int IW = $clog2(NUM_REQ);
  logic en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] rel;
  logic [TIMEOUT_WIDTH-1:0] timeout_cycles;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0] grant_idx;
  logic busy;
  logic timeout_pulse;
  logic [IW-1:0] timeout_idx;
  modport master (
    output en, req, rel, timeout_cycles,
    input grant, grant_idx, busy, timeout_pulse, timeout_idx
  );
  modport slave (
    input en, req, rel, timeout_cycles,
    output grant, grant_idx, busy, timeout_pulse, timeout_idx
  );
endinterface

// File: rtl/ros2_buf_arbiter.sv
// ros2_buf_arbiter: round-robin single-buffer ownership arbiter with hold watchdog (clk, rst, bus slave)
module ros2_buf_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_WIDTH = 24
) (
  input logic clk,
  input logic rst,
  ros2_buf_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, OWNED, GAP} state_t;
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant, grant_n;
  logic [IW-1:0] gidx, gidx_n, last, last_n, tidx, tidx_n, win, j;
  logic [TIMEOUT_WIDTH-1:0] cnt, cnt_n;
  logic tp, tp_n, busy, found, expire;
  always_comb begin
    win = last;
    found = 1'b0;
    j = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(last) + k) % NUM_REQ);
      if (!found && bus.req[j]) begin
        found = 1'b1;
        win = j;
      end
    end
  end
  assign expire = (bus.timeout_cycles != '0) && (cnt == bus.timeout_cycles - TIMEOUT_WIDTH'(1));
  always_comb begin
    state_n = state;
    grant_n = grant;
    gidx_n = gidx;
    last_n = last;
    cnt_n = cnt;
    tp_n = 1'b0;
    tidx_n = tidx;
    if (!bus.en) begin
      state_n = IDLE;
      grant_n = '0;
    end else if (state == OWNED) begin
      if (bus.rel[gidx]) begin
        state_n = GAP;
        grant_n = '0;
      end else if (expire) begin
        state_n = GAP;
        grant_n = '0;
        tp_n = 1'b1;
        tidx_n = gidx;
      end else begin
        cnt_n = &cnt ? cnt : cnt + TIMEOUT_WIDTH'(1);
      end
    end else if (found) begin
      state_n = OWNED;
      grant_n = NUM_REQ'(1) << win;
      gidx_n = win;
      last_n = win;
      cnt_n = '0;
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      gidx <= '0;
      last <= IW'(NUM_REQ - 1);
      cnt <= '0;
      tp <= 1'b0;
      tidx <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      gidx <= gidx_n;
      last <= last_n;
      cnt <= cnt_n;
      tp <= tp_n;
      tidx <= tidx_n;
      busy <= |grant_n;
    end
  end
  assign bus.grant = grant;
  assign bus.grant_idx = gidx;
  assign bus.busy = busy;
  assign bus.timeout_pulse = tp;
  assign bus.timeout_idx = tidx;
endmodule

// File: tb/tb_ros2_buf_arbiter.sv
// tb_ros2_buf_arbiter: directed and random checks of the arbiter against a behavioural model
module tb_ros2_buf_arbiter;
  localparam int N = 4;
  localparam int TW = 24;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ros2_buf_arbiter_if #(.NUM_REQ(N), .TIMEOUT_WIDTH(TW)) bus ();
  ros2_buf_arbiter #(.NUM_REQ(N), .TIMEOUT_WIDTH(TW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int passed = 0;
  int total = 0;
  int owner = -1;
  int last_w = N - 1;
  int gidx = 0;
  int held = 0;
  int tidx = 0;
  int tp = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic model_edge();
    tp = 0;
    if (rst) begin
      owner = -1;
      last_w = N - 1;
      gidx = 0;
      held = 0;
      tidx = 0;
    end else if (!bus.en) begin
      owner = -1;
    end else if (owner >= 0) begin
      if (bus.rel[owner]) owner = -1;
      else if (bus.timeout_cycles != 0 && held == int'(bus.timeout_cycles)) begin
        tp = 1;
        tidx = owner;
        owner = -1;
      end else held++;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_w + k) % N;
        if (bus.req[c]) begin
          owner = c;
          last_w = c;
          gidx = c;
          held = 1;
          break;
        end
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("grant", 32'(bus.grant), owner >= 0 ? 32'(1) << owner : 32'(0));
    chk("grant_idx", 32'(bus.grant_idx), 32'(gidx));
    chk("busy", 32'(bus.busy), owner >= 0 ? 32'(1) : 32'(0));
    chk("timeout_pulse", 32'(bus.timeout_pulse), 32'(tp));
    chk("timeout_idx", 32'(bus.timeout_idx), 32'(tidx));
  endtask
  task automatic do_reset();
    bus.req = '0;
    bus.rel = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    logic [N-1:0] order [5];
    int cnt;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.en = 1'b1;
    bus.req = '0;
    bus.rel = '0;
    bus.timeout_cycles = '0;
    do_reset();
    chk("reset_grant", 32'(bus.grant), 32'(0));
    chk("reset_busy", 32'(bus.busy), 32'(0));
    // single requester grant and release
    bus.req = 4'b0001;
    step();
    chk("t1_grant", 32'(bus.grant), 32'(1));
    bus.req = '0;
    repeat (3) step();
    chk("t1_busy_held", 32'(bus.busy), 32'(1));
    bus.rel = 4'b0001;
    step();
    bus.rel = '0;
    chk("t1_released", 32'(bus.grant), 32'(0));
    // round robin with all requesting
    do_reset();
    bus.req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_order", 32'(bus.grant), 32'(order[i]));
      if (i < 4) begin
        step();
        bus.rel = bus.grant;
        step();
        bus.rel = '0;
        chk("t2_gap", 32'(bus.grant), 32'(0));
        step();
      end
    end
    // watchdog expiry
    do_reset();
    bus.timeout_cycles = TW'(10);
    bus.req = 4'b0100;
    step();
    bus.req = '0;
    cnt = (bus.grant != '0) ? 1 : 0;
    for (int i = 0; i < 20 && bus.grant != '0; i++) begin
      step();
      if (bus.grant != '0) cnt++;
    end
    chk("t3_hold_len", 32'(cnt), 32'(10));
    chk("t3_pulse", 32'(bus.timeout_pulse), 32'(1));
    chk("t3_idx", 32'(bus.timeout_idx), 32'(2));
    step();
    chk("t3_pulse_clear", 32'(bus.timeout_pulse), 32'(0));
    // release on the final allowed cycle wins over the watchdog
    do_reset();
    bus.req = 4'b0010;
    step();
    bus.req = '0;
    repeat (9) step();
    chk("t4_still_owned", 32'(bus.grant), 32'(4'b0010));
    bus.rel = 4'b0010;
    step();
    bus.rel = '0;
    chk("t4_no_pulse", 32'(bus.timeout_pulse), 32'(0));
    chk("t4_released", 32'(bus.grant), 32'(0));
    // foreign release ignored, disable revokes, pointer wraps
    bus.timeout_cycles = '0;
    do_reset();
    bus.req = 4'b0010;
    step();
    bus.req = '0;
    bus.rel = 4'b0100;
    step();
    bus.rel = '0;
    chk("t5_foreign_rel", 32'(bus.grant), 32'(4'b0010));
    bus.en = 1'b0;
    step();
    chk("t5_disabled", 32'(bus.grant), 32'(0));
    bus.en = 1'b1;
    bus.req = 4'b0011;
    step();
    chk("t5_wrap", 32'(bus.grant), 32'(4'b0001));
    bus.req = '0;
    bus.rel = 4'b0001;
    step();
    bus.rel = '0;
    // reset in the middle of a grant
    bus.req = 4'b1000;
    step();
    bus.req = '0;
    repeat (3) step();
    chk("t6_owned", 32'(bus.grant), 32'(4'b1000));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_grant", 32'(bus.grant), 32'(0));
    chk("t6_rst_idx", 32'(bus.grant_idx), 32'(0));
    bus.req = 4'b1001;
    step();
    chk("t6_first", 32'(bus.grant), 32'(4'b0001));
    bus.req = '0;
    // random traffic
    for (int s = 0; s < 20; s++) begin
      bus.en = 1'b0;
      bus.req = '0;
      bus.rel = '0;
      step();
      bus.timeout_cycles = (s % 3 == 0) ? TW'(0) : TW'($urandom_range(1, 12));
      for (int c = 0; c < 60; c++) begin
        bus.req = N'($urandom);
        bus.rel = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        bus.en = ($urandom_range(0, 15) != 0);
        step();
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
